// File: rtl/alu3_cdb_broadcast_pkg.sv
// Shared types and widths for the ALU3 common-data-bus transmit block.
package alu3_cdb_broadcast_pkg;

   localparam int REGNAME_W = 6;
   localparam int TAG_W     = 6;
   localparam int DATA_W    = 32;
   localparam int EXPTR_W   = 4;

   // One buffered result as it travels from the ALU3 stage onto the CDB.
   typedef struct packed {
      logic [REGNAME_W-1:0] regname;
      logic                 sysreg;
      logic                 writeback;
      logic [DATA_W-1:0]    data;
      logic [TAG_W-1:0]     tag;
      logic                 ordered;
   } cdb_payload_t;

   localparam int PAYLOAD_W = $bits(cdb_payload_t);

   // Next in-order execution pointer; wraps naturally at 2**EXPTR_W.
   function automatic logic [EXPTR_W-1:0] exptr_next(input logic [EXPTR_W-1:0] ptr);
      return ptr + EXPTR_W'(1);
   endfunction

endpackage

// File: rtl/alu3_cdb_broadcast_if.sv
// Result-in / CDB-out bundle of the ALU3 broadcast block.
interface alu3_cdb_broadcast_if;
   import alu3_cdb_broadcast_pkg::*;

   logic                 iFLUSH;
   logic                 iRESULT_VALID;
   logic                 oRESULT_BUSY;
   logic [REGNAME_W-1:0] iRESULT_DESTINATION_REGNAME;
   logic                 iRESULT_DESTINATION_SYSREG;
   logic                 iRESULT_WRITEBACK;
   logic [DATA_W-1:0]    iRESULT_DATA;
   logic [TAG_W-1:0]     iRESULT_COMMIT_TAG;
   logic                 iRESULT_EX_ORDERED;
   logic                 iCOMMIT_BUSY;
   logic                 oCDB_VALID;
   logic [REGNAME_W-1:0] oCDB_DESTINATION_REGNAME;
   logic                 oCDB_DESTINATION_SYSREG;
   logic                 oCDB_WRITEBACK;
   logic [DATA_W-1:0]    oCDB_DATA;
   logic [TAG_W-1:0]     oCDB_COMMIT_TAG;
   logic [EXPTR_W-1:0]   oEX_EXECUTION_POINTER;

   // Producer / consumer environment side.
   modport master (
      output iFLUSH, iRESULT_VALID, iRESULT_DESTINATION_REGNAME, iRESULT_DESTINATION_SYSREG,
             iRESULT_WRITEBACK, iRESULT_DATA, iRESULT_COMMIT_TAG, iRESULT_EX_ORDERED, iCOMMIT_BUSY,
      input  oRESULT_BUSY, oCDB_VALID, oCDB_DESTINATION_REGNAME, oCDB_DESTINATION_SYSREG,
             oCDB_WRITEBACK, oCDB_DATA, oCDB_COMMIT_TAG, oEX_EXECUTION_POINTER
   );

   // Broadcast block side.
   modport slave (
      input  iFLUSH, iRESULT_VALID, iRESULT_DESTINATION_REGNAME, iRESULT_DESTINATION_SYSREG,
             iRESULT_WRITEBACK, iRESULT_DATA, iRESULT_COMMIT_TAG, iRESULT_EX_ORDERED, iCOMMIT_BUSY,
      output oRESULT_BUSY, oCDB_VALID, oCDB_DESTINATION_REGNAME, oCDB_DESTINATION_SYSREG,
             oCDB_WRITEBACK, oCDB_DATA, oCDB_COMMIT_TAG, oEX_EXECUTION_POINTER
   );

endinterface

// File: rtl/alu3_cdb_fifo.sv
// Generic synchronous FIFO; head is read combinationally, storage is
// zeroed on reset and on clear so an empty FIFO presents an all-zero head.
module alu3_cdb_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 47,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [PTR_W:0]   count_o
);

   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push_s, pop_s;

   assign full_o  = (count_q == DEPTH_CNT);
   assign empty_o = (count_q == {(PTR_W+1){1'b0}});
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign push_s  = push_i & ~full_o;
   assign pop_s   = pop_i & ~empty_o;

   // Next pointers and occupancy from the accepted push/pop pair.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // State and storage update; reset and clear both empty and zero the FIFO.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {(PTR_W+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
         end
      end
   end

endmodule

// File: rtl/alu3_cdb_broadcast.sv
// ALU3 CDB transmit end: buffers results in order, broadcasts the head when
// commit is not busy, and advances the in-order execution pointer on every
// broadcast of an ordered result.
module alu3_cdb_broadcast
   import alu3_cdb_broadcast_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic                 iCLOCK,
   input  logic                 iRESET_SYNC,
   alu3_cdb_broadcast_if.slave  bus
);

   cdb_payload_t       wdata_s;
   cdb_payload_t       head_s;
   logic               push_s;
   logic               pop_s;
   logic               full_s;
   logic               empty_s;
   logic [PTR_W:0]     count_s;
   logic [EXPTR_W-1:0] exptr_q, exptr_d;

   assign wdata_s = '{regname:   bus.iRESULT_DESTINATION_REGNAME,
                      sysreg:    bus.iRESULT_DESTINATION_SYSREG,
                      writeback: bus.iRESULT_WRITEBACK,
                      data:      bus.iRESULT_DATA,
                      tag:       bus.iRESULT_COMMIT_TAG,
                      ordered:   bus.iRESULT_EX_ORDERED};

   // Busy comes from the registered full flag only, so a full FIFO refuses a
   // push even in a cycle where it also pops.
   assign push_s = bus.iRESULT_VALID & ~full_s;
   assign pop_s  = (count_s != {(PTR_W+1){1'b0}}) & ~empty_s & ~bus.iCOMMIT_BUSY;

   alu3_cdb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (PAYLOAD_W),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clk_i   (iCLOCK),
      .rst_i   (iRESET_SYNC),
      .clr_i   (bus.iFLUSH),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .wdata_i (wdata_s),
      .rdata_o (head_s),
      .full_o  (full_s),
      .empty_o (empty_s),
      .count_o (count_s)
   );

   // Execution pointer next state: flush clears it, an ordered broadcast bumps it.
   always_comb begin
      exptr_d = exptr_q;
      if (bus.iFLUSH) begin
         exptr_d = {EXPTR_W{1'b0}};
      end else if (pop_s && head_s.ordered) begin
         exptr_d = exptr_next(exptr_q);
      end else begin
         exptr_d = exptr_q;
      end
   end

   // Execution pointer register.
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         exptr_q <= {EXPTR_W{1'b0}};
      end else begin
         exptr_q <= exptr_d;
      end
   end

   assign bus.oRESULT_BUSY             = full_s;
   assign bus.oCDB_VALID               = pop_s;
   assign bus.oCDB_DESTINATION_REGNAME = head_s.regname;
   assign bus.oCDB_DESTINATION_SYSREG  = head_s.sysreg;
   assign bus.oCDB_WRITEBACK           = head_s.writeback;
   assign bus.oCDB_DATA                = head_s.data;
   assign bus.oCDB_COMMIT_TAG          = head_s.tag;
   assign bus.oEX_EXECUTION_POINTER    = exptr_q;

endmodule

// File: tb/tb_alu3_cdb_broadcast.sv
// Self-checking bench for alu3_cdb_broadcast: directed vector table,
// hand-written pointer/flush/reset sequences, and a randomized run against
// a queue-based reference model.
module tb_alu3_cdb_broadcast;
   import alu3_cdb_broadcast_pkg::*;

   localparam int DEPTH = 4;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   alu3_cdb_broadcast_if bus();

   alu3_cdb_broadcast #(.DEPTH(DEPTH), .PTR_W(2)) dut (
      .iCLOCK      (clk),
      .iRESET_SYNC (rst),
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   typedef struct {
      logic         vld;
      logic         cb;
      cdb_payload_t p;
      logic         e_busy;
      logic         e_valid;
      logic [5:0]   e_reg;
      logic         e_wb;
      logic [31:0]  e_data;
      logic [5:0]   e_tag;
      logic [3:0]   e_ptr;
   } vec_t;

   vec_t vecs[15];

   function automatic cdb_payload_t mkp(logic [5:0] r, logic wb, logic [31:0] d, logic [5:0] t, logic o);
      cdb_payload_t p;
      p.regname = r; p.sysreg = 1'b0; p.writeback = wb; p.data = d; p.tag = t; p.ordered = o;
      return p;
   endfunction

   function automatic vec_t mkv(logic vld, logic cb, cdb_payload_t p, logic eb, logic ev,
                                logic [5:0] er, logic ew, logic [31:0] ed, logic [5:0] et, logic [3:0] ep);
      vec_t v;
      v.vld = vld; v.cb = cb; v.p = p; v.e_busy = eb; v.e_valid = ev;
      v.e_reg = er; v.e_wb = ew; v.e_data = ed; v.e_tag = et; v.e_ptr = ep;
      return v;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic rs, logic fl, logic vld, logic cb, cdb_payload_t p);
      rst                             = rs;
      bus.iFLUSH                      = fl;
      bus.iRESULT_VALID               = vld;
      bus.iCOMMIT_BUSY                = cb;
      bus.iRESULT_DESTINATION_REGNAME = p.regname;
      bus.iRESULT_DESTINATION_SYSREG  = p.sysreg;
      bus.iRESULT_WRITEBACK           = p.writeback;
      bus.iRESULT_DATA                = p.data;
      bus.iRESULT_COMMIT_TAG          = p.tag;
      bus.iRESULT_EX_ORDERED          = p.ordered;
   endtask

   // Apply inputs just after the falling edge and settle before checking.
   task automatic step(logic rs, logic fl, logic vld, logic cb, cdb_payload_t p);
      @(negedge clk);
      drive(rs, fl, vld, cb, p);
      #1;
   endtask

   task automatic do_reset();
      cdb_payload_t z;
      z = '0;
      step(1'b1, 1'b0, 1'b0, 1'b0, z);
      step(1'b1, 1'b0, 1'b0, 1'b0, z);
      step(1'b0, 1'b0, 1'b0, 1'b0, z);
   endtask

   task automatic chk_payload_zero(string name);
      chk({name, " payload"}, {bus.oCDB_DESTINATION_REGNAME, bus.oCDB_DESTINATION_SYSREG,
                               bus.oCDB_WRITEBACK, bus.oCDB_DATA, bus.oCDB_COMMIT_TAG}, 64'd0);
   endtask

   // Buffer three results with pointer at 7, then clear with flush or reset.
   task automatic clear_seq(logic use_reset);
      cdb_payload_t z;
      string nm;
      z  = '0;
      nm = use_reset ? "rst" : "flush";
      do_reset();
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, mkp(6'd1, 1'b1, 32'(i), 6'(i), 1'b1));
         step(1'b0, 1'b0, 1'b0, 1'b0, z);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b1, mkp(6'd2, 1'b1, 32'hC0DE_0000 + 32'(i), 6'h30 + 6'(i), 1'b1));
      end
      step(use_reset, ~use_reset, 1'b1, 1'b0, mkp(6'd3, 1'b1, 32'hFFFF_FFFF, 6'h3F, 1'b1));
      chk({nm, " pre ptr"}, 64'(bus.oEX_EXECUTION_POINTER), 64'd7);
      chk({nm, " pre valid"}, 64'(bus.oCDB_VALID), 64'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, z);
      chk({nm, " post valid"}, 64'(bus.oCDB_VALID), 64'd0);
      chk({nm, " post busy"}, 64'(bus.oRESULT_BUSY), 64'd0);
      chk({nm, " post ptr"}, 64'(bus.oEX_EXECUTION_POINTER), 64'd0);
      chk_payload_zero({nm, " post"});
      step(1'b0, 1'b0, 1'b0, 1'b0, z);
      chk({nm, " stays empty"}, 64'(bus.oCDB_VALID), 64'd0);
   endtask

   initial begin
      cdb_payload_t z;
      cdb_payload_t a;
      cdb_payload_t q[$];
      cdb_payload_t p;
      int           mptr;
      logic         rs, fl, vld, cb;
      logic         e_busy, e_valid;

      n_tests = 0;
      n_fail  = 0;
      z = '0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, z);

      // ---------------- directed vector table ----------------
      a = mkp(6'h05, 1'b1, 32'hDEAD_BEEF, 6'h11, 1'b1);
      vecs[0]  = mkv(1'b1, 1'b0, a, 1'b0, 1'b0, 6'h00, 1'b0, 32'h0, 6'h00, 4'd0);
      vecs[1]  = mkv(1'b0, 1'b0, z, 1'b0, 1'b1, 6'h05, 1'b1, 32'hDEAD_BEEF, 6'h11, 4'd0);
      vecs[2]  = mkv(1'b0, 1'b0, z, 1'b0, 1'b0, 6'h00, 1'b0, 32'h0, 6'h00, 4'd1);
      for (int i = 0; i < 4; i++) begin
         vecs[3+i] = mkv(1'b1, 1'b1, mkp(6'h10 + 6'(i), 1'b1, 32'hA000_0000 + 32'(i), 6'h21 + 6'(i), 1'b0),
                         1'b0, 1'b0, 6'h00, 1'b0, 32'h0, 6'h00, 4'd1);
      end
      vecs[7]  = mkv(1'b1, 1'b1, mkp(6'h14, 1'b1, 32'hA000_0004, 6'h25, 1'b0),
                     1'b1, 1'b0, 6'h00, 1'b0, 32'h0, 6'h00, 4'd1);
      vecs[8]  = mkv(1'b1, 1'b0, mkp(6'h15, 1'b1, 32'hA000_0005, 6'h26, 1'b0),
                     1'b1, 1'b1, 6'h10, 1'b1, 32'hA000_0000, 6'h21, 4'd1);
      vecs[9]  = mkv(1'b0, 1'b0, z, 1'b0, 1'b1, 6'h11, 1'b1, 32'hA000_0001, 6'h22, 4'd1);
      vecs[10] = mkv(1'b0, 1'b0, z, 1'b0, 1'b1, 6'h12, 1'b1, 32'hA000_0002, 6'h23, 4'd1);
      vecs[11] = mkv(1'b0, 1'b0, z, 1'b0, 1'b1, 6'h13, 1'b1, 32'hA000_0003, 6'h24, 4'd1);
      vecs[12] = mkv(1'b1, 1'b0, mkp(6'h3F, 1'b0, 32'h1234_5678, 6'h2A, 1'b1),
                     1'b0, 1'b0, 6'h00, 1'b0, 32'h0, 6'h00, 4'd1);
      vecs[13] = mkv(1'b0, 1'b0, z, 1'b0, 1'b1, 6'h3F, 1'b0, 32'h1234_5678, 6'h2A, 4'd1);
      vecs[14] = mkv(1'b0, 1'b0, z, 1'b0, 1'b0, 6'h00, 1'b0, 32'h0, 6'h00, 4'd2);

      do_reset();
      chk("reset busy", 64'(bus.oRESULT_BUSY), 64'd0);
      chk("reset valid", 64'(bus.oCDB_VALID), 64'd0);
      chk("reset ptr", 64'(bus.oEX_EXECUTION_POINTER), 64'd0);
      chk_payload_zero("reset");

      for (int i = 0; i < 15; i++) begin
         step(1'b0, 1'b0, vecs[i].vld, vecs[i].cb, vecs[i].p);
         chk($sformatf("vec%0d busy", i), 64'(bus.oRESULT_BUSY), 64'(vecs[i].e_busy));
         chk($sformatf("vec%0d valid", i), 64'(bus.oCDB_VALID), 64'(vecs[i].e_valid));
         chk($sformatf("vec%0d ptr", i), 64'(bus.oEX_EXECUTION_POINTER), 64'(vecs[i].e_ptr));
         if (vecs[i].e_valid) begin
            chk($sformatf("vec%0d reg", i), 64'(bus.oCDB_DESTINATION_REGNAME), 64'(vecs[i].e_reg));
            chk($sformatf("vec%0d wb", i), 64'(bus.oCDB_WRITEBACK), 64'(vecs[i].e_wb));
            chk($sformatf("vec%0d data", i), 64'(bus.oCDB_DATA), 64'(vecs[i].e_data));
            chk($sformatf("vec%0d tag", i), 64'(bus.oCDB_COMMIT_TAG), 64'(vecs[i].e_tag));
         end
      end

      // ---------------- execution pointer wrap ----------------
      do_reset();
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, mkp(6'd4, 1'b1, 32'(i), 6'(i), 1'b1));
         chk($sformatf("wrap ptr%0d", i), 64'(bus.oEX_EXECUTION_POINTER), 64'(i));
         step(1'b0, 1'b0, 1'b0, 1'b0, z);
         chk($sformatf("wrap valid%0d", i), 64'(bus.oCDB_VALID), 64'd1);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0, mkp(6'd4, 1'b1, 32'h55, 6'h15, 1'b0));
      chk("wrap ptr to 0", 64'(bus.oEX_EXECUTION_POINTER), 64'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, z);
      chk("unordered bcast valid", 64'(bus.oCDB_VALID), 64'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, z);
      chk("unordered keeps ptr", 64'(bus.oEX_EXECUTION_POINTER), 64'd0);

      // ---------------- flush / reset with buffered entries ----------------
      clear_seq(1'b0);
      clear_seq(1'b1);

      // ---------------- randomized run against queue model ----------------
      do_reset();
      q.delete();
      mptr = 0;
      for (int c = 0; c < 400; c++) begin
         rs  = ($urandom_range(0, 63) == 0);
         fl  = ($urandom_range(0, 31) == 0);
         vld = ($urandom_range(0, 2) != 0);
         cb  = ($urandom_range(0, 2) == 0);
         p.regname   = 6'($urandom);
         p.sysreg    = 1'($urandom);
         p.writeback = 1'($urandom);
         p.data      = $urandom;
         p.tag       = 6'($urandom);
         p.ordered   = 1'($urandom);
         step(rs, fl, vld, cb, p);

         e_busy  = (q.size() == DEPTH);
         e_valid = (q.size() != 0) && !cb;
         chk($sformatf("rnd%0d busy", c), 64'(bus.oRESULT_BUSY), 64'(e_busy));
         chk($sformatf("rnd%0d valid", c), 64'(bus.oCDB_VALID), 64'(e_valid));
         chk($sformatf("rnd%0d ptr", c), 64'(bus.oEX_EXECUTION_POINTER), 64'(mptr));
         if (e_valid) begin
            chk($sformatf("rnd%0d head", c),
                {bus.oCDB_DESTINATION_REGNAME, bus.oCDB_DESTINATION_SYSREG, bus.oCDB_WRITEBACK,
                 bus.oCDB_DATA, bus.oCDB_COMMIT_TAG},
                {q[0].regname, q[0].sysreg, q[0].writeback, q[0].data, q[0].tag});
         end

         if (rs || fl) begin
            q.delete();
            mptr = 0;
         end else begin
            if (e_valid) begin
               if (q[0].ordered) mptr = (mptr + 1) % 16;
               void'(q.pop_front());
            end
            if (vld && !e_busy) q.push_back(p);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu3_cdb_broadcast.md
Name: alu3_cdb_broadcast

Overview:
Transmit end of the ALU3 common data bus (CDB). The ALU3 execution stage hands finished results to this block. It buffers them in a small in-order FIFO and broadcasts one per cycle on the CDB channel that the reservation entries and the commit unit snoop. It also owns the 4-bit in-order execution pointer that reservation entries compare against their registered pointer. The pointer advances each time an ordered result is broadcast.

Parameters:
DEPTH, 4, result FIFO depth in entries; must be a power of two, 2..16
PTR_W, 2, log2(DEPTH)

Ports:
iCLOCK  in  1  clock
iRESET_SYNC  in  1  reset, synchronous, active-high
iFLUSH  in  1  pipeline flush; discards buffered results and resets the pointer
iRESULT_VALID  in  1  result offered by the ALU3 execution stage
oRESULT_BUSY  out  1  FIFO full; the result is not accepted this cycle
iRESULT_DESTINATION_REGNAME  in  6  destination physical register name
iRESULT_DESTINATION_SYSREG  in  1  destination is a system register
iRESULT_WRITEBACK  in  1  result writes a register
iRESULT_DATA  in  32  result value
iRESULT_COMMIT_TAG  in  6  commit tag of the instruction
iRESULT_EX_ORDERED  in  1  instruction held the in-order execution pointer
iCOMMIT_BUSY  in  1  commit side cannot take a broadcast this cycle
oCDB_VALID  out  1  broadcast valid
oCDB_DESTINATION_REGNAME  out  6  broadcast destination register name
oCDB_DESTINATION_SYSREG  out  1  broadcast destination is a system register
oCDB_WRITEBACK  out  1  broadcast writes a register
oCDB_DATA  out  32  broadcast data
oCDB_COMMIT_TAG  out  6  broadcast commit tag
oEX_EXECUTION_POINTER  out  4  in-order execution pointer

Behaviour:
- Clock and reset: single clock iCLOCK. iRESET_SYNC is synchronous and active-high, sampled on the rising edge of iCLOCK.
- Priority: iRESET_SYNC > iFLUSH > normal operation.
- Reset/flush state: count=0, read and write pointers=0, oEX_EXECUTION_POINTER=0.
- Reset/flush outputs: oRESULT_BUSY=0, oCDB_VALID=0; all oCDB_* payload outputs read 0 (storage cleared).
- Accept (push): iRESULT_VALID & !oRESULT_BUSY. The entry {regname, sysreg, writeback, data, tag, ordered} is written at the write pointer.
- oRESULT_BUSY = (count == DEPTH). It is a function of registered count only and never depends on the same-cycle pop.
  - At full with a simultaneous pop, the push is still refused; the producer retries next cycle.
- Broadcast (pop): oCDB_VALID = (count != 0) & !iCOMMIT_BUSY. oCDB_* payload is the FIFO head, driven combinationally from storage.
  - A pop occurs when oCDB_VALID is high. There are no other back-pressure inputs.
- Latency: an accepted result is broadcast at the earliest on the cycle after acceptance. There is no same-cycle bypass. Strict FIFO order.
- oCDB_WRITEBACK=0 entries are still broadcast with oCDB_VALID=1, so commit sees the tag. Receivers ignore them because they qualify on WRITEBACK.
- Count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on push & pop in the same cycle
- Pointers wrap modulo DEPTH.
- Execution pointer: on a pop whose head entry has ordered=1, oEX_EXECUTION_POINTER <= pointer+1, wrapping 15->0. The new value is visible the cycle after the broadcast.
- iCOMMIT_BUSY held high: the head is held stable and oCDB_VALID=0. Pushes continue until full.
- iFLUSH in the same cycle as a push or pop: the flush wins, the push is dropped and the FIFO is empty next cycle.
- Reset mid-stream: same as flush; nothing is broadcast on the following cycle.

Decomposition:
- Shared package holds:
  - CDB payload record: regname 6, sysreg 1, writeback 1, data 32, tag 6, ordered 1 (47 bits)
  - width constants: REGNAME_W=6, TAG_W=6, DATA_W=32, EXPTR_W=4
- One natural sub-module: alu3_cdb_fifo, a generic synchronous FIFO with DEPTH and WIDTH parameters, full/empty and count outputs.
- The top level adds the commit-busy gating and the execution-pointer counter.

Test Plan:
- Reset, then push {reg=0x05, wb=1, data=0xDEADBEEF, tag=0x11, ord=1} -> next cycle oCDB_VALID=1, regname=0x05, data=0xDEADBEEF, tag=0x11; the cycle after, oEX_EXECUTION_POINTER=1.
- iCOMMIT_BUSY=1, push 4 results -> oRESULT_BUSY=1 after the 4th; a 5th push is refused. Release busy -> 4 broadcasts on consecutive cycles in push order, then oCDB_VALID=0.
- Full FIFO with simultaneous push and pop -> push refused, count goes 4->3, oRESULT_BUSY=0 next cycle.
- 16 ordered broadcasts from pointer 0 -> pointer counts 1..15 then wraps to 0. Ordered=0 entries leave the pointer unchanged.
- Push {wb=0, tag=0x2A} -> broadcast with oCDB_VALID=1, oCDB_WRITEBACK=0, tag=0x2A.
- 3 entries buffered and pointer=7, assert iFLUSH with a concurrent push -> next cycle count=0, oCDB_VALID=0, pointer=0. Same check using iRESET_SYNC.
